// File: rtl/search_stall_unit_pkg.sv
// Shared definitions for the search/stall unit: modes, ALU ops, opcodes, FSM states.
package search_stall_unit_pkg;

    // Requested stall modes; the first two start a bracket search.
    typedef enum logic [2:0] {
        SEARCH_FWD = 3'd0,
        SEARCH_BWD = 3'd1,
        WRITE_PC   = 3'd2,
        READ_PC    = 3'd3,
        WRITE_POP  = 3'd4
    } STALL_STATE;

    // Direction of the last nesting counter update.
    typedef enum logic {
        ALU_INC = 1'b0,
        ALU_DEC = 1'b1
    } ALU_OP;

    // Fetched opcodes; CBF opens a bracket, CBB closes one.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PLUS  = 3'd1,
        OP_MINUS = 3'd2,
        OP_LEFT  = 3'd3,
        OP_RIGHT = 3'd4,
        OP_OUT   = 3'd5,
        CBF      = 3'd6,
        CBB      = 3'd7
    } op_code;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        WAIT   = 2'd2,
        ERROR  = 2'd3
    } fsm_state_t;

    // True for the two modes that run a bracket search.
    function automatic logic is_search_mode(input STALL_STATE mode);
        return (mode == SEARCH_FWD) || (mode == SEARCH_BWD);
    endfunction

endpackage

// File: rtl/search_stall_unit_counter.sv
// Bracket nesting counter: synchronous load to 1, saturating increment,
// decrement that stops at zero, plus decode flags for the sequencer.
module nest_counter
    import search_stall_unit_pkg::*;
#(
    parameter int NEST_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic              dec,
    output logic [NEST_W-1:0] count,
    output logic              at_max,
    output logic              at_one
);

    logic [NEST_W-1:0] count_r;

    assign count  = count_r;
    assign at_max = (count_r == {NEST_W{1'b1}});
    assign at_one = (count_r == {{(NEST_W-1){1'b0}}, 1'b1});

    // Counter register: load has priority, increment never wraps past all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {NEST_W{1'b0}};
        end else if (load) begin
            count_r <= {{(NEST_W-1){1'b0}}, 1'b1};
        end else if (inc && !at_max) begin
            count_r <= count_r + {{(NEST_W-1){1'b0}}, 1'b1};
        end else if (dec && (count_r != {NEST_W{1'b0}})) begin
            count_r <= count_r - {{(NEST_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/search_stall_unit.sv
// Pipeline stall sequencer: holds the pipeline during bracket searches
// (tracking nesting depth) or for a fixed number of cycles.
module search_stall_unit
    import search_stall_unit_pkg::*;
#(
    parameter int NEST_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enter,
    input  STALL_STATE        starting,
    input  op_code            instruction,
    input  logic              instr_valid,
    output logic              stalling,
    output logic              done,
    output logic [NEST_W-1:0] nest_depth,
    output logic              overflow,
    output ALU_OP             alu_op
);

    // Wait counter starts at WAIT_CYCLES; done is raised in the cycle it reads 1.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    fsm_state_t  state_r;
    logic        search_bwd_r;
    logic [3:0]  wait_cnt_r;
    logic        stalling_r;
    logic        done_r;
    logic        overflow_r;
    ALU_OP       alu_op_r;

    logic        up_s;
    logic        down_s;
    logic        cnt_load_s;
    logic        cnt_inc_s;
    logic        cnt_dec_s;
    logic        at_max_s;
    logic        at_one_s;

    assign stalling = stalling_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign alu_op   = alu_op_r;

    // Map the fetched opcode to deeper/shallower nesting for the latched direction.
    always_comb begin
        up_s   = 1'b0;
        down_s = 1'b0;
        if (instr_valid) begin
            if (search_bwd_r) begin
                up_s   = (instruction == CBB);
                down_s = (instruction == CBF);
            end else begin
                up_s   = (instruction == CBF);
                down_s = (instruction == CBB);
            end
        end else begin
            up_s   = 1'b0;
            down_s = 1'b0;
        end
    end

    // Counter control derived from the current state.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        cnt_dec_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_load_s = enter && is_search_mode(starting);
            end
            SEARCH: begin
                if (!done_r) begin
                    cnt_inc_s = up_s && !at_max_s;
                    cnt_dec_s = down_s;
                end else begin
                    cnt_inc_s = 1'b0;
                    cnt_dec_s = 1'b0;
                end
            end
            default: begin
                cnt_load_s = 1'b0;
            end
        endcase
    end

    nest_counter #(
        .NEST_W (NEST_W)
    ) u_nest_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load_s),
        .inc    (cnt_inc_s),
        .dec    (cnt_dec_s),
        .count  (nest_depth),
        .at_max (at_max_s),
        .at_one (at_one_s)
    );

    // Sequencer FSM with registered stall/done/overflow/alu outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            search_bwd_r <= 1'b0;
            wait_cnt_r   <= 4'd0;
            stalling_r   <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            alu_op_r     <= ALU_INC;
        end else begin
            case (state_r)
                IDLE: begin
                    alu_op_r <= ALU_INC;
                    if (enter) begin
                        stalling_r <= 1'b1;
                        if (is_search_mode(starting)) begin
                            state_r      <= SEARCH;
                            search_bwd_r <= (starting == SEARCH_BWD);
                            done_r       <= 1'b0;
                        end else begin
                            state_r    <= WAIT;
                            wait_cnt_r <= WAIT_LOAD;
                            done_r     <= (WAIT_LOAD == 4'd1);
                        end
                    end else begin
                        stalling_r <= 1'b0;
                        done_r     <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (done_r) begin
                        // Completion cycle is over: release the pipeline.
                        state_r    <= IDLE;
                        stalling_r <= 1'b0;
                        done_r     <= 1'b0;
                        alu_op_r   <= ALU_INC;
                    end else if (up_s) begin
                        alu_op_r <= ALU_INC;
                        if (at_max_s) begin
                            overflow_r <= 1'b1;
                            state_r    <= ERROR;
                        end else begin
                            overflow_r <= overflow_r;
                        end
                    end else if (down_s) begin
                        alu_op_r <= ALU_DEC;
                        done_r   <= at_one_s;
                    end else begin
                        alu_op_r <= alu_op_r;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r != 4'd0) begin
                        wait_cnt_r <= wait_cnt_r - 4'd1;
                    end else begin
                        wait_cnt_r <= 4'd0;
                    end
                    if (done_r) begin
                        state_r    <= IDLE;
                        stalling_r <= 1'b0;
                        done_r     <= 1'b0;
                    end else begin
                        done_r <= (wait_cnt_r == 4'd2);
                    end
                end
                ERROR: begin
                    // Locked until reset.
                    stalling_r <= 1'b1;
                    done_r     <= 1'b0;
                    overflow_r <= 1'b1;
                end
                default: begin
                    state_r    <= IDLE;
                    stalling_r <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/search_stall_unit.md
SEARCH_STALL_UNIT -- requirements
Module: search_stall_unit

Interface
REQ-001 Parameter NEST_W, default 8, width of the bracket nesting counter (legal range 2..16).
REQ-002 Parameter WAIT_CYCLES, default 1, stall length in cycles for the fixed-latency modes WRITE_PC, READ_PC and WRITE_POP (legal range 1..15).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 enter  input  1  request to begin a stall sequence; sampled only in IDLE.
REQ-006 starting  input  STALL_STATE  requested mode (SEARCH_FWD, SEARCH_BWD, WRITE_PC, READ_PC, WRITE_POP), captured with enter.
REQ-007 instruction  input  op_code  opcode currently fetched during a search.
REQ-008 instr_valid  input  1  instruction is valid this cycle; the counter updates only when high.
REQ-009 stalling  output  1  pipeline hold; high from the cycle after an accepted enter until the sequence completes.
REQ-010 done  output  1  single-cycle pulse in the cycle the sequence completes.
REQ-011 nest_depth  output  NEST_W  current nesting counter value.
REQ-012 overflow  output  1  sticky error flag; set when the counter would exceed 2^NEST_W-1.
REQ-013 alu_op  output  ALU_OP  ALU_INC or ALU_DEC for the last counter update; ALU_INC when idle.

Function
REQ-014 FSM states: IDLE, SEARCH, WAIT, ERROR.
REQ-015 IDLE, enter high, mode SEARCH_FWD or SEARCH_BWD: load nest_depth=1, latch direction, go to SEARCH.
REQ-016 IDLE, enter high, any fixed mode: load wait counter=WAIT_CYCLES, go to WAIT.
REQ-017 enter outside IDLE: ignored, with no effect on state or counters.
REQ-018 SEARCH forward, instr_valid high, CBF: nest_depth+1 (alu_op=ALU_INC); CBB: nest_depth-1 (alu_op=ALU_DEC).
REQ-019 SEARCH backward: roles reversed; CBB increments and CBF decrements.
REQ-020 SEARCH, any other opcode or instr_valid low: nest_depth holds.
REQ-021 SEARCH, decrement taking nest_depth from 1 to 0: done=1 that cycle, stalling=0 and IDLE from the next cycle.
REQ-022 SEARCH, increment with nest_depth=2^NEST_W-1: no wrap; overflow=1, nest_depth holds, go to ERROR.
REQ-023 WAIT: decrement the wait counter each cycle; at 0 pulse done and return to IDLE; total stall = WAIT_CYCLES cycles.
REQ-024 ERROR: stalling stays 1, done stays 0, overflow stays 1; the only exit is rst_n.
REQ-025 Latency: stalling rises exactly one cycle after the enter edge; done and the stalling fall occur on consecutive edges.

Reset
REQ-026 rst_n low, asynchronously: state=IDLE, stalling=0, done=0, nest_depth=0, overflow=0, alu_op=ALU_INC, wait counter=0.
REQ-027 Reset mid-search or mid-wait abandons the sequence with no done pulse.

Structure
REQ-028 STALL_STATE (with SEARCH_FWD/SEARCH_BWD), ALU_OP, op_code and the FSM state enum live in the shared definitions package.
REQ-029 The nesting counter is one sub-module, nest_counter, with sync load, inc/dec and saturation flag, parametrised by NEST_W.

Verification
REQ-030 Forward search: SEARCH_FWD with stream CBF,x,CBB,CBB -> nest_depth 1,2,2,1,0; done on 4th valid cycle; stalling drops next cycle.
REQ-031 Backward search: SEARCH_BWD with stream CBF -> done after 1 valid cycle; with CBB,CBF,CBF -> done on 3rd.
REQ-032 Fixed wait: WAIT_CYCLES=3, WRITE_PC -> stalling high exactly 3 cycles, one done pulse; enter during the wait has no effect.
REQ-033 Overflow: NEST_W=2, SEARCH_FWD, CBF x3 -> nest_depth saturates at 3, overflow=1, ERROR, stalling held until rst_n.
REQ-034 Async reset asserted mid-search at nest_depth=2 -> all outputs reset values immediately, with no done pulse.
REQ-035 instr_valid gaps: forward stream CBB with instr_valid low for 5 cycles first -> nest_depth holds 1, done only on the valid CBB.
